fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the single-issue RV32 core: owns the PC, issues word reads to the instruction memory, buffers returned instructions and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flushes buffered and in-flight fetches) and a halt request.
- Sits between the instruction memory and the decode stage.

---
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues word reads to instruction memory,
// buffers returned words and presents them to decode over a valid/ready handshake.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        busy
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [31:0]      pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic             drop;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      buf_pc    [BUF_DEPTH];
    logic [31:0]      buf_instr [BUF_DEPTH];

    logic             pop;
    logic             redir;
    logic             issue;
    logic             resp_hit;
    logic             push;
    logic [OCC_W-1:0] occ;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        redir      = 1'b0;
        occ        = '0;
        issue      = 1'b0;
        resp_hit   = 1'b0;
        push       = 1'b0;

        pop      = if_valid && if_ready;
        redir    = redirect_valid && (state != ST_BOOT);
        // Slots already promised: buffered entries plus the outstanding read, less this cycle's pop
        occ      = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        issue    = (state == ST_RUN) && !halt && !redir && (occ < OCC_W'(BUF_DEPTH));
        resp_hit = imem_resp_valid && inflight;
        push     = resp_hit && !drop && !redir;

        case (state)
            ST_BOOT: state_next = halt ? ST_HALT : ST_RUN;
            ST_RUN:  state_next = (halt && !redir) ? ST_HALT : ST_RUN;
            ST_HALT: state_next = halt ? ST_HALT : ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

    // PC, outstanding-read tracking and buffer bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            drop        <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (redir) begin
                pc <= redirect_pc & ~32'h3;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else if (imem_resp_valid) begin
                inflight <= 1'b0;
            end

            // A redirect with the answer still outstanding marks that late answer as stale
            if (redir && inflight && !imem_resp_valid) begin
                drop <= 1'b1;
            end else if (resp_hit) begin
                drop <= 1'b0;
            end

            if (redir) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Buffer storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= inflight_pc;
            buf_instr[wr_ptr] <= imem_resp_data;
        end
    end

    assign imem_req_valid = issue;
    assign imem_req_addr  = issue ? pc : 32'h0;
    assign if_valid       = (count != '0);
    assign if_pc          = if_valid ? buf_pc[rd_ptr] : 32'h0;
    assign if_instr       = if_valid ? buf_instr[rd_ptr] : 32'h0;
    assign busy           = inflight || if_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a stream-level
// model (delivered and requested PCs advance by 4 and restart at each redirect target).
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic        s_busy;
    logic        s_ready;

    logic [31:0] dq_pc[$];
    logic [31:0] dq_instr[$];
    logic [31:0] rq[$];

    fetch_ctrl #(
        .RESET_PC (32'h0000_0100),
        .BUF_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction

    // One cycle: snapshot outputs mid-cycle, then play memory answering one cycle later
    task automatic tick();
        @(negedge clk);
        s_req   = imem_req_valid;
        s_addr  = imem_req_addr;
        s_valid = if_valid;
        s_pc    = if_pc;
        s_instr = if_instr;
        s_busy  = busy;
        s_ready = if_ready;
        if (s_valid && s_ready) begin
            dq_pc.push_back(s_pc);
            dq_instr.push_back(s_instr);
        end
        if (s_req) rq.push_back(s_addr);
        @(posedge clk);
        #1;
        imem_resp_valid = s_req;
        imem_resp_data  = s_req ? word(s_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic restart();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        if_ready       = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        dq_pc.delete();
        dq_instr.delete();
        rq.delete();
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        if_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({s_req, s_valid, s_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got req/valid/busy=%b expected 000", {s_req, s_valid, s_busy});
        end
        n_tests++;
        if ({s_addr, s_pc, s_instr} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h pc=%h instr=%h expected all 0", s_addr, s_pc, s_instr);
        end
        rst_n = 1'b1;
        dq_pc.delete(); dq_instr.delete(); rq.delete();
        tick();
        n_tests++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_idle: got req=%b expected 0", s_req);
        end
        tick();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h expected 1 00000100", s_req, s_addr);
        end
        tick();
        n_tests++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_valid: got valid=%b expected 0 on cycle 2", s_valid);
        end
        tick();
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== 32'h1040) begin
            n_fail++;
            $display("FAIL first_instr: got valid=%b pc=%h instr=%h expected 1 00000100 00001040",
                     s_valid, s_pc, s_instr);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_tests++;
            if (s_valid !== 1'b1 || s_pc !== 32'h100 + 32'(4 * k) || s_instr !== word(32'h100 + 32'(4 * k))) begin
                n_fail++;
                $display("FAIL stream_%0d: got valid=%b pc=%h instr=%h expected pc %h",
                         k, s_valid, s_pc, s_instr, 32'h100 + 32'(4 * k));
            end
        end
        // Reset while streaming; the answer to the last pre-reset request must vanish
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dq_pc.delete(); dq_instr.delete(); rq.delete();
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | s_valid;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale: got a valid instr in cycles 0-2 after reset, expected none");
        end
        tick();
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL midreset_first: got valid=%b pc=%h expected 1 00000100", s_valid, s_pc);
        end
    endtask

    task automatic test_stall();
        logic bad;
        int   nreq;
        restart();
        tick(); tick(); tick();
        if_ready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== 32'h1040 || s_req !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b pc=%h instr=%h req=%b expected 1 00000100 00001040 0",
                     s_valid, s_pc, s_instr, s_req);
        end
        nreq = rq.size();
        n_tests++;
        if (nreq != 2) begin
            n_fail++;
            $display("FAIL stall_reqs: got %0d requests expected 2", nreq);
        end
        if_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_tests++;
        if (dq_pc.size() != 6) begin
            n_fail++;
            $display("FAIL stall_count: got %0d deliveries expected 6", dq_pc.size());
        end
        for (int i = 0; i < dq_pc.size(); i++) begin
            n_tests++;
            if (dq_pc[i] !== 32'h100 + 32'(4 * i) || dq_instr[i] !== word(32'h100 + 32'(4 * i))) begin
                n_fail++;
                $display("FAIL stall_seq_%0d: got pc=%h instr=%h expected pc %h", i, dq_pc[i], dq_instr[i],
                         32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_d [5] = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h208};
        restart();
        tick(); tick(); tick();
        if_ready = 1'b0;
        tick(); tick(); tick();
        if_ready = 1'b1;
        tick(); tick();
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        n_tests++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_noreq: got req=%b expected 0", s_req);
        end
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        tick();
        n_tests++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush: got valid=%b expected 0", s_valid);
        end
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_target: got req=%b addr=%h expected 1 00000200", s_req, s_addr);
        end
        for (int k = 0; k < 4; k++) tick();
        n_tests++;
        if (dq_pc.size() != 5) begin
            n_fail++;
            $display("FAIL redir_count: got %0d deliveries expected 5", dq_pc.size());
        end
        for (int i = 0; i < 5 && i < dq_pc.size(); i++) begin
            n_tests++;
            if (dq_pc[i] !== exp_d[i] || dq_instr[i] !== word(exp_d[i])) begin
                n_fail++;
                $display("FAIL redir_seq_%0d: got pc=%h instr=%h expected pc %h", i, dq_pc[i], dq_instr[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [6] = '{32'h100, 32'h104, 32'h108, 32'h600, 32'h604, 32'h608};
        logic [31:0] exp_r [10] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h400,
                                    32'h600, 32'h604, 32'h608, 32'h60C, 32'h610};
        restart();
        for (int k = 0; k < 5; k++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'h108 || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pop: got valid=%b pc=%h req=%b expected 1 00000108 0", s_valid, s_pc, s_req);
        end
        redirect_valid = 1'b0;
        tick();
        n_tests++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got valid=%b expected 0", s_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        tick();
        redirect_pc = 32'h600;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h600) begin
            n_fail++;
            $display("FAIL b2b_last_wins: got req=%b addr=%h expected 1 00000600", s_req, s_addr);
        end
        for (int k = 0; k < 4; k++) tick();
        n_tests++;
        if (dq_pc.size() != 6 || rq.size() != 10) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d deliveries %0d requests expected 6 10", dq_pc.size(), rq.size());
        end
        for (int i = 0; i < 6 && i < dq_pc.size(); i++) begin
            n_tests++;
            if (dq_pc[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_deliv_%0d: got pc=%h expected %h", i, dq_pc[i], exp_d[i]);
            end
        end
        for (int i = 0; i < 10 && i < rq.size(); i++) begin
            n_tests++;
            if (rq[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL b2b_req_%0d: got addr=%h expected %h", i, rq[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic anyreq;
        restart();
        for (int k = 0; k < 6; k++) tick();
        halt = 1'b1;
        anyreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            anyreq = anyreq | s_req;
        end
        n_tests++;
        if (anyreq !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_noreq: got a request while halted, expected none");
        end
        n_tests++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_drained: got busy=%b valid=%b expected 0 0", s_busy, s_valid);
        end
        halt = 1'b0;
        tick();
        n_tests++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit_gap: got req=%b expected 0", s_req);
        end
        tick();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h114) begin
            n_fail++;
            $display("FAIL halt_resume: got req=%b addr=%h expected 1 00000114", s_req, s_addr);
        end
        for (int k = 0; k < 4; k++) tick();
        n_tests++;
        if (dq_pc.size() != 8) begin
            n_fail++;
            $display("FAIL halt_count: got %0d deliveries expected 8", dq_pc.size());
        end
        for (int i = 0; i < dq_pc.size(); i++) begin
            n_tests++;
            if (dq_pc[i] !== 32'h100 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL halt_seq_%0d: got pc=%h expected %h", i, dq_pc[i], 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        restart();
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_top: got req=%b addr=%h expected 1 fffffffc", s_req, s_addr);
        end
        tick();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_zero: got req=%b addr=%h expected 1 00000000", s_req, s_addr);
        end
        tick(); tick();
        n_tests++;
        if (dq_pc.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d deliveries expected 3", dq_pc.size());
        end else begin
            n_tests++;
            if (dq_pc[1] !== 32'hFFFF_FFFC || dq_instr[1] !== 32'h4000_0FFF ||
                dq_pc[2] !== 32'h0 || dq_instr[2] !== 32'h1000) begin
                n_fail++;
                $display("FAIL wrap_deliv: got %h/%h %h/%h expected fffffffc/40000fff 00000000/00001000",
                         dq_pc[1], dq_instr[1], dq_pc[2], dq_instr[2]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic [31:0] exp_r;
        logic [31:0] tgt;
        logic [31:0] prev_pc;
        logic        prev_hold;
        logic        h;
        logic        r;
        int          idle;
        restart();
        tick();
        exp_d = 32'h100;
        exp_r = 32'h100;
        prev_hold = 1'b0;
        prev_pc = 32'h0;
        idle = 0;
        for (int c = 0; c < 3000; c++) begin
            if_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) halt = !halt;
            r = ($urandom_range(19) == 0);
            tgt = $urandom;
            redirect_valid = r;
            redirect_pc = tgt;
            h = halt;
            tick();
            redirect_valid = 1'b0;
            if (prev_hold) begin
                n_tests++;
                if (s_valid !== 1'b1 || s_pc !== prev_pc) begin
                    n_fail++;
                    $display("FAIL rnd_hold c%0d: got valid=%b pc=%h expected 1 %h", c, s_valid, s_pc, prev_pc);
                end
            end
            if (s_valid && s_ready) begin
                n_tests++;
                if (s_pc !== exp_d || s_instr !== word(exp_d)) begin
                    n_fail++;
                    $display("FAIL rnd_deliv c%0d: got pc=%h instr=%h expected %h %h", c, s_pc, s_instr,
                             exp_d, word(exp_d));
                end
                exp_d = s_pc + 32'd4;
            end
            if (s_req) begin
                n_tests++;
                if (s_addr !== exp_r || h || r) begin
                    n_fail++;
                    $display("FAIL rnd_req c%0d: got addr=%h halt=%b redir=%b expected %h with halt/redir 0",
                             c, s_addr, h, r, exp_r);
                end
                exp_r = s_addr + 32'd4;
            end
            if (r) begin
                exp_d = tgt & ~32'h3;
                exp_r = tgt & ~32'h3;
            end
            prev_hold = s_valid && !s_ready && !r;
            prev_pc = s_pc;
            if (h || r || !s_ready || s_valid) idle = 0;
            else idle++;
            if (idle > 6) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd_stall c%0d: got no delivery for %0d ready cycles expected at most 6", c, idle);
                idle = 0;
            end
        end
        halt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        if_ready = 1'b1;
        test_reset();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
